// File: rtl/spi_led_pkg.sv
// spi_led_pkg: shared constants and types for the SPI LED configuration slave.
//   OP_MASK / OP_PSC : command opcodes carried in the first byte of a frame
//   SIG_BYTE         : signature returned on MISO as byte 0 of every frame
//   state_t          : frame-level state machine encoding
package spi_led_pkg;

  localparam logic [7:0] OP_MASK  = 8'h01;
  localparam logic [7:0] OP_PSC   = 8'h02;
  localparam logic [7:0] SIG_BYTE = 8'hA5;

  typedef enum logic [2:0] {IDLE, CMD, D0, D1, DONE, DRAIN} state_t;

  function automatic logic is_valid_op(input logic [7:0] op);
    return (op == OP_MASK) || (op == OP_PSC);
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: STAGES-deep synchronizer for one asynchronous input, with
// registered rise/fall pulses.
//   clk, rst_n : system clock, synchronous active-low reset
//   din        : asynchronous input
//   sync       : synchronized level, aligned so it changes in the same cycle
//                that rise/fall pulse
//   rise, fall : one-cycle pulses on a synchronized 0->1 / 1->0 transition
module spi_sync_edge #(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      chain <= {STAGES{RST_VAL}};
      sync  <= RST_VAL;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      chain <= {chain[STAGES-2:0], din};
      sync  <= chain[STAGES-1];
      rise  <= chain[STAGES-1] & ~sync;
      fall  <= ~chain[STAGES-1] & sync;
    end
  end

endmodule

// File: rtl/spi_led_cfg.sv
// spi_led_cfg: SPI mode-0 slave (MSB first), oversampled in the clk domain,
// holding the LED blink configuration.
//   clk, rst_n          : system clock (>= 4x spi_sck), synchronous active-low reset
//   spi_sck, spi_cs_n,
//   spi_mosi, spi_miso  : SPI bus (inputs asynchronous to clk)
//   led_mask            : LED enable mask, bit i enables LED(i+1)
//   blink_psc           : blink half-period prescale in clk cycles
//   cfg_valid           : one-cycle pulse when led_mask or blink_psc updates
//   frame_err           : one-cycle pulse on a bad opcode or truncated frame
// Build option SPI_READBACK_EN: MISO returns 0xA5 then {3'b000, led_mask}
// per byte; otherwise spi_miso is tied to 0.
module spi_led_cfg
  import spi_led_pkg::*;
#(
  parameter logic [15:0] PSC_RESET   = 16'd256,
  parameter logic [4:0]  MASK_RESET  = 5'b11111,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        spi_sck,
  input  logic        spi_cs_n,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic [4:0]  led_mask,
  output logic [15:0] blink_psc,
  output logic        cfg_valid,
  output logic        frame_err
);

  logic sck_sync, sck_rise, sck_fall;
  logic cs_sync, cs_rise, cs_fall;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck (
    .clk(clk), .rst_n(rst_n), .din(spi_sck),
    .sync(sck_sync), .rise(sck_rise), .fall(sck_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
    .clk(clk), .rst_n(rst_n), .din(spi_cs_n),
    .sync(cs_sync), .rise(cs_rise), .fall(cs_fall)
  );

  // One extra stage so mosi lines up with the registered edge pulses.
  logic [SYNC_STAGES:0] mosi_chain;
  logic                 mosi_s;
  assign mosi_s = mosi_chain[SYNC_STAGES];

  state_t     state, state_d;
  logic [2:0] bit_cnt;
  logic [7:0] shreg, hold;
  logic       op_psc;
  logic [7:0] byte_val;
  logic       byte_done;
  logic       commit_mask, commit_psc, load_op, load_hold, err;

  assign byte_val = {shreg[6:0], mosi_s};
  // The 8th edge still completes a byte when cs_n rises in the same cycle.
  assign byte_done = sck_rise && (bit_cnt == 3'd7) && (!cs_sync || cs_rise);

  always_comb begin
    state_d     = state;
    commit_mask = 1'b0;
    commit_psc  = 1'b0;
    load_op     = 1'b0;
    load_hold   = 1'b0;
    err         = 1'b0;
    case (state)
      IDLE: if (cs_fall) state_d = CMD;
      CMD: if (byte_done) begin
        if (is_valid_op(byte_val)) begin
          load_op = 1'b1;
          state_d = D0;
        end else begin
          err     = 1'b1;
          state_d = DRAIN;
        end
      end
      D0: if (byte_done) begin
        if (op_psc) begin
          load_hold = 1'b1;
          state_d   = D1;
        end else begin
          commit_mask = 1'b1;
          state_d     = DONE;
        end
      end
      D1: if (byte_done) begin
        commit_psc = 1'b1;
        state_d    = DONE;
      end
      default: ;
    endcase
    if (cs_rise) begin
      state_d = IDLE;
      if (!byte_done && ((state == CMD && bit_cnt != '0) || state == D0 || state == D1))
        err = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mosi_chain <= '0;
      state      <= IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      hold       <= '0;
      op_psc     <= 1'b0;
      led_mask   <= MASK_RESET;
      blink_psc  <= PSC_RESET;
      cfg_valid  <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      mosi_chain <= {mosi_chain[SYNC_STAGES-1:0], spi_mosi};
      state      <= state_d;
      if (byte_done || cs_sync) begin
        bit_cnt <= '0;
        shreg   <= '0;
      end else if (sck_rise) begin
        bit_cnt <= bit_cnt + 3'd1;
        shreg   <= byte_val;
      end
      if (load_op)     op_psc    <= (byte_val == OP_PSC);
      if (load_hold)   hold      <= byte_val;
      if (commit_mask) led_mask  <= byte_val[4:0];
      if (commit_psc)  blink_psc <= {hold, byte_val};
      cfg_valid <= commit_mask | commit_psc;
      frame_err <= err;
    end
  end

  logic unused_sck;

`ifdef SPI_READBACK_EN
  logic [7:0] tx_sr;
  logic       tx_reload;

  // The falling edge after a completed byte presents the next byte's MSB,
  // so the status byte is captured there rather than at byte_done.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_sr     <= '0;
      tx_reload <= 1'b0;
    end else if (cs_fall) begin
      tx_sr     <= SIG_BYTE;
      tx_reload <= 1'b0;
    end else if (!cs_sync) begin
      if (sck_fall) begin
        tx_sr     <= tx_reload ? {3'b000, led_mask} : {tx_sr[6:0], 1'b0};
        tx_reload <= 1'b0;
      end else if (byte_done) begin
        tx_reload <= 1'b1;
      end
    end
  end

  assign spi_miso   = tx_sr[7] & ~cs_sync;
  assign unused_sck = sck_sync;
`else
  assign spi_miso   = 1'b0;
  assign unused_sck = ^{sck_sync, sck_fall};
`endif

endmodule

// File: tb/tb_spi_led_cfg.sv
// tb_spi_led_cfg: directed bench for spi_led_cfg. A frame-level model predicts
// the committed configuration and pulse counts; a per-cycle monitor checks the
// outputs stay within {before, after} and only change with cfg_valid.
module tb_spi_led_cfg;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        spi_sck = 1'b0;
  logic        spi_cs_n = 1'b1;
  logic        spi_mosi = 1'b0;
  logic        spi_miso;
  logic [4:0]  led_mask;
  logic [15:0] blink_psc;
  logic        cfg_valid;
  logic        frame_err;

  always #5 clk = ~clk;

  spi_led_cfg #(
    .PSC_RESET(16'd256),
    .MASK_RESET(5'b11111),
    .SYNC_STAGES(2)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .spi_sck(spi_sck), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
    .led_mask(led_mask), .blink_psc(blink_psc),
    .cfg_valid(cfg_valid), .frame_err(frame_err)
  );

  int checks = 0;
  int errors = 0;

  logic [4:0]  exp_mask, nxt_mask, last_mask;
  logic [15:0] exp_psc, nxt_psc, last_psc;
  int          exp_cfg, exp_err, cfg_seen, err_seen;
  int          cs_hi = 0;
  bit          tracking = 1'b0;
  logic [7:0]  tx_bytes [4];
  logic [7:0]  rx_bytes [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Frame-level rules: what a frame of nb whole bytes plus xbits stray bits does.
  task automatic model_frame(input int nb, input int xbits);
    nxt_mask = exp_mask;
    nxt_psc  = exp_psc;
    exp_cfg  = 0;
    exp_err  = 0;
    if (nb == 0) begin
      exp_err = (xbits > 0) ? 1 : 0;
    end else if (tx_bytes[0] == 8'h01) begin
      if (nb >= 2) begin
        nxt_mask = tx_bytes[1][4:0];
        exp_cfg  = 1;
      end else exp_err = 1;
    end else if (tx_bytes[0] == 8'h02) begin
      if (nb >= 3) begin
        nxt_psc = {tx_bytes[1], tx_bytes[2]};
        exp_cfg = 1;
      end else exp_err = 1;
    end else begin
      exp_err = 1;
    end
  endtask

  task automatic run_frame(input string name, input int nb, input int xbits);
    model_frame(nb, xbits);
    cfg_seen = 0;
    err_seen = 0;
    for (int k = 0; k < 4; k++) rx_bytes[k] = 8'h00;
    @(negedge clk);
    spi_cs_n = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < nb * 8 + xbits; i++) begin
      spi_mosi = tx_bytes[i / 8][7 - (i % 8)];
      spi_sck  = 1'b0;
      repeat (4) @(negedge clk);
      spi_sck  = 1'b1;
      repeat (4) @(negedge clk);
      rx_bytes[i / 8][7 - (i % 8)] = spi_miso;
    end
    spi_sck = 1'b0;
    repeat (4) @(negedge clk);
    spi_cs_n = 1'b1;
    repeat (12) @(negedge clk);
    check({name, " led_mask"}, led_mask, nxt_mask);
    check({name, " blink_psc"}, blink_psc, nxt_psc);
    check({name, " cfg_valid pulses"}, cfg_seen, exp_cfg);
    check({name, " frame_err pulses"}, err_seen, exp_err);
    exp_mask = nxt_mask;
    exp_psc  = nxt_psc;
  endtask

  always @(negedge clk) begin
    if (rst_n && tracking) begin
      cfg_seen += int'(cfg_valid);
      err_seen += int'(frame_err);
      check("mask in {old,new}", (led_mask === exp_mask) || (led_mask === nxt_mask), 1);
      check("psc in {old,new}", (blink_psc === exp_psc) || (blink_psc === nxt_psc), 1);
      if (led_mask !== last_mask || blink_psc !== last_psc)
        check("update with cfg_valid", cfg_valid, 1);
      cs_hi = spi_cs_n ? cs_hi + 1 : 0;
      if (cs_hi >= 6) check("miso idle", spi_miso, 0);
`ifndef SPI_READBACK_EN
      check("miso tied", spi_miso, 0);
`endif
    end
    last_mask = led_mask;
    last_psc  = blink_psc;
  end

  initial begin
    #10_000_000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset led_mask", led_mask, 5'b11111);
    check("reset blink_psc", blink_psc, 16'd256);
    check("reset cfg_valid", cfg_valid, 0);
    check("reset frame_err", frame_err, 0);
    check("reset spi_miso", spi_miso, 0);
    exp_mask = 5'b11111;
    nxt_mask = 5'b11111;
    exp_psc  = 16'd256;
    nxt_psc  = 16'd256;
    rst_n    = 1'b1;
    tracking = 1'b1;
    repeat (4) @(negedge clk);

    tx_bytes = '{8'h01, 8'h15, 8'h00, 8'h00};
    run_frame("mask write", 2, 0);
    check("mask write literal", led_mask, 5'b10101);
    check("mask write psc literal", blink_psc, 16'd256);

    tx_bytes = '{8'h02, 8'h12, 8'h34, 8'h00};
    run_frame("psc write", 3, 0);
    check("psc write literal", blink_psc, 16'h1234);

    tx_bytes = '{8'h7F, 8'hFF, 8'h00, 8'h00};
    run_frame("bad opcode", 2, 0);

    tx_bytes = '{8'h02, 8'hAB, 8'h00, 8'h00};
    run_frame("trunc data", 2, 0);
    check("trunc data psc literal", blink_psc, 16'h1234);

    run_frame("trunc opcode", 0, 3);
    run_frame("empty frame", 0, 0);

    tx_bytes = '{8'h02, 8'h00, 8'h00, 8'h00};
    run_frame("psc zero", 3, 0);
    check("psc zero literal", blink_psc, 16'h0000);

    tx_bytes = '{8'h01, 8'hE6, 8'h00, 8'h00};
    run_frame("mask upper bits", 2, 0);
    check("mask upper bits literal", led_mask, 5'b00110);

    tx_bytes = '{8'h01, 8'h1F, 8'h00, 8'h00};
    run_frame("readback", 2, 0);
    check("readback mask literal", led_mask, 5'b11111);
`ifdef SPI_READBACK_EN
    check("readback byte0", rx_bytes[0], 8'hA5);
    check("readback byte1", rx_bytes[1], 8'h06);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
